// File: rtl/tl_a_arb_pkg.sv
// Shared TileLink A-channel types and beat-count helpers for the A arbiter and D router.
// Pure declarations: no logic, no latency, no flow control.
package tl_a_arb_pkg;

    localparam int BEAT_BYTES_LOG2 = 3;
    localparam int MAX_SIZE        = 6;
    localparam int TL_SRC_W        = 7;
    localparam int TL_ADDR_W       = 30;
    localparam int BEAT_MAX        = 1 << (MAX_SIZE - BEAT_BYTES_LOG2);
    localparam int CNT_W           = $clog2(BEAT_MAX);

    localparam logic [2:0] PUT_FULL      = 3'd0;
    localparam logic [2:0] PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] ARITHMETIC    = 3'd2;
    localparam logic [2:0] LOGICAL       = 3'd3;
    localparam logic [2:0] GET           = 3'd4;
    localparam logic [2:0] INTENT        = 3'd5;
    localparam logic [2:0] ACQUIRE_BLOCK = 3'd6;
    localparam logic [2:0] ACQUIRE_PERM  = 3'd7;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } arb_state_e;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [3:0]           size;
        logic [TL_SRC_W-1:0]  source;
        logic [TL_ADDR_W-1:0] address;
        logic [7:0]           mask;
        logic [63:0]          data;
    } a_beat_t;

    function automatic logic has_data(input logic [2:0] opcode);
        return (opcode <= LOGICAL);
    endfunction

    // Oversized requests are clamped so the beat counter can never wrap.
    function automatic logic [CNT_W:0] beats_from_size(input logic [2:0] opcode,
                                                       input logic [3:0] size);
        logic [3:0]     s;
        logic [CNT_W:0] b;
        s = (size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : size;
        b = (CNT_W+1)'(1);
        if (has_data(opcode) && (s > 4'(BEAT_BYTES_LOG2)))
            b = (CNT_W+1)'(1) << (s - 4'(BEAT_BYTES_LOG2));
        return b;
    endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Round-robin picker: first set request at or after ptr_i (mod N), as one-hot and index.
// Purely combinational; no flow control of its own.
module tl_rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o
);

    always_comb begin
        logic found;
        int   j;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!found && req_i[j]) begin
                found       = 1'b1;
                gnt_oh_o[j] = 1'b1;
                gnt_idx_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tl_a_channel_arbiter.sv
// Round-robin TL A-channel arbiter, grant locked across multi-beat bursts; zero latency,
// winner's in_ready mirrors out_ready. Optional stall/protocol checker: TL_A_ARB_ASSERT_EN.
module tl_a_channel_arbiter
    import tl_a_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int SRC_W  = TL_SRC_W,
    parameter int ADDR_W = TL_ADDR_W,
    parameter int IW     = $clog2(N)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [N-1:0]          in_valid,
    output logic [N-1:0]          in_ready,
    input  logic [N*3-1:0]        in_opcode,
    input  logic [N*4-1:0]        in_size,
    input  logic [N*SRC_W-1:0]    in_source,
    input  logic [N*ADDR_W-1:0]   in_address,
    input  logic [N*8-1:0]        in_mask,
    input  logic [N*64-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_opcode,
    output logic [3:0]            out_size,
    output logic [ADDR_W-1:0]     out_address,
    output logic [7:0]            out_mask,
    output logic [63:0]           out_data,
    output logic [SRC_W+IW-1:0]   out_source,
    output logic [IW-1:0]         grant_idx,
    output logic                  locked
);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    lock_idx_q, lock_idx_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [N-1:0]     pick_oh;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    win_idx;
    logic             burst;
    logic             fire;
    logic [CNT_W:0]   beats;
    a_beat_t          beat;

    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    tl_rr_picker #(.N(N), .IW(IW)) u_picker (
        .req_i     (in_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx)
    );

    assign burst   = (state_q == S_BURST);
    assign win_idx = burst ? lock_idx_q : pick_idx;

    // Struct field widths follow the package; SRC_W/ADDR_W are expected to match them.
    always_comb begin
        beat         = '0;
        beat.opcode  = in_opcode[int'(win_idx)*3 +: 3];
        beat.size    = in_size[int'(win_idx)*4 +: 4];
        beat.source  = in_source[int'(win_idx)*SRC_W +: SRC_W];
        beat.address = in_address[int'(win_idx)*ADDR_W +: ADDR_W];
        beat.mask    = in_mask[int'(win_idx)*8 +: 8];
        beat.data    = in_data[int'(win_idx)*64 +: 64];
    end

    // Combinational outputs are forced quiet while reset is asserted.
    assign out_valid   = reset_n & (burst ? in_valid[lock_idx_q] : |in_valid);
    assign grant_idx   = reset_n ? win_idx : '0;
    assign locked      = burst;
    assign out_opcode  = beat.opcode;
    assign out_size    = beat.size;
    assign out_address = beat.address;
    assign out_mask    = beat.mask;
    assign out_data    = beat.data;
    assign out_source  = {grant_idx, beat.source};

    always_comb begin
        in_ready = '0;
        if (reset_n && out_ready)
            in_ready = burst ? (N'(1) << lock_idx_q) : pick_oh;
    end

    assign fire  = out_valid & out_ready;
    assign beats = beats_from_size(beat.opcode, beat.size);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    if (beats == (CNT_W+1)'(1)) begin
                        rr_ptr_d = inc_mod(pick_idx);
                    end else begin
                        state_d    = S_BURST;
                        lock_idx_d = pick_idx;
                        beat_cnt_d = CNT_W'(beats - (CNT_W+1)'(1));
                    end
                end
            end
            S_BURST: begin
                if (fire) begin
                    beat_cnt_d = beat_cnt_q - 1'b1;
                    if (beat_cnt_q == CNT_W'(1)) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = inc_mod(lock_idx_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef TL_A_ARB_ASSERT_EN
`ifndef SYNTHESIS
`ifndef PRINTF_COND
`define PRINTF_COND 1'b1
`endif
`ifndef STOP_COND
`define STOP_COND 1'b1
`endif
    logic          stall_q;
    logic          burst_stall_q;
    logic [IW-1:0] stall_idx_q;
    a_beat_t       stall_beat_q;
    a_beat_t       held_now;

    always_comb begin
        held_now         = '0;
        held_now.opcode  = in_opcode[int'(stall_idx_q)*3 +: 3];
        held_now.size    = in_size[int'(stall_idx_q)*4 +: 4];
        held_now.source  = in_source[int'(stall_idx_q)*SRC_W +: SRC_W];
        held_now.address = in_address[int'(stall_idx_q)*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q       <= 1'b0;
            burst_stall_q <= 1'b0;
            stall_idx_q   <= '0;
            stall_beat_q  <= '0;
        end else begin
            stall_q       <= out_valid & ~out_ready;
            burst_stall_q <= burst & out_valid & ~out_ready;
            stall_idx_q   <= win_idx;
            stall_beat_q  <= beat;
        end
    end

    always @(posedge clock) begin
        if (reset_n) begin
            if (burst_stall_q && !in_valid[lock_idx_q]) begin
                if (`PRINTF_COND) $display("tl_a_arb: valid dropped on stalled burst");
                if (`STOP_COND) $fatal(1, "tl_a_arb: valid dropped on stalled burst");
            end
            if (stall_q && in_valid[stall_idx_q] &&
                ((held_now.opcode  != stall_beat_q.opcode) ||
                 (held_now.size    != stall_beat_q.size)   ||
                 (held_now.source  != stall_beat_q.source) ||
                 (held_now.address != stall_beat_q.address))) begin
                if (`PRINTF_COND) $display("tl_a_arb: stalled request changed");
                if (`STOP_COND) $fatal(1, "tl_a_arb: stalled request changed");
            end
            if (out_valid && (beat.size > 4'(MAX_SIZE))) begin
                if (`PRINTF_COND) $display("tl_a_arb: size above max");
                if (`STOP_COND) $fatal(1, "tl_a_arb: size above max");
            end
            if ($countones(in_ready) > 1) begin
                if (`PRINTF_COND) $display("tl_a_arb: multiple in_ready");
                if (`STOP_COND) $fatal(1, "tl_a_arb: multiple in_ready");
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_tl_a_channel_arbiter.sv
// Directed bench for tl_a_channel_arbiter: round-robin order, burst lock, stalls, async reset.
module tb_tl_a_channel_arbiter;

    logic          clock;
    logic          reset_n;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [11:0]   in_opcode;
    logic [15:0]   in_size;
    logic [27:0]   in_source;
    logic [119:0]  in_address;
    logic [31:0]   in_mask;
    logic [255:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_opcode;
    logic [3:0]    out_size;
    logic [29:0]   out_address;
    logic [7:0]    out_mask;
    logic [63:0]   out_data;
    logic [8:0]    out_source;
    logic [1:0]    grant_idx;
    logic          locked;

    logic [2:0]  op_r  [4];
    logic [3:0]  sz_r  [4];
    logic [6:0]  src_r [4];
    logic [29:0] adr_r [4];

    int n_chk = 0;
    int n_err = 0;

    tl_a_channel_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_size     (in_size),
        .in_source   (in_source),
        .in_address  (in_address),
        .in_mask     (in_mask),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_size    (out_size),
        .out_address (out_address),
        .out_mask    (out_mask),
        .out_data    (out_data),
        .out_source  (out_source),
        .grant_idx   (grant_idx),
        .locked      (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        in_opcode  = '0;
        in_size    = '0;
        in_source  = '0;
        in_address = '0;
        in_mask    = '0;
        in_data    = '0;
        for (int i = 0; i < 4; i++) begin
            in_opcode[i*3 +: 3]   = op_r[i];
            in_size[i*4 +: 4]     = sz_r[i];
            in_source[i*7 +: 7]   = src_r[i];
            in_address[i*30 +: 30] = adr_r[i];
            in_mask[i*8 +: 8]     = 8'hF0 | 8'(i);
            in_data[i*64 +: 64]   = 64'hDA7A_0000_0000_0000 + 64'(i);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op, input logic [3:0] sz);
        in_valid[i] = v;
        op_r[i]     = op;
        sz_r[i]     = sz;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    int exp_rr [6] = '{3, 0, 1, 2, 3, 0};
    logic rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        in_valid  = '0;
        src_r[0] = 7'h15; src_r[1] = 7'h2A; src_r[2] = 7'h33; src_r[3] = 7'h4C;
        adr_r[0] = 30'h0000_1000; adr_r[1] = 30'h0000_2040;
        adr_r[2] = 30'h0000_3080; adr_r[3] = 30'h0000_40C0;
        for (int i = 0; i < 4; i++) begin
            op_r[i] = 3'd4;
            sz_r[i] = 4'd3;
        end

        // Reset: outputs quiet even with a request pending
        set_req(1, 1'b1, 3'd4, 4'd3);
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_locked", locked, 0);
        @(posedge clock); #1;
        reset_n  = 1'b1;
        in_valid = '0;

        // Single-beat Get from req0
        set_req(0, 1'b1, 3'd4, 4'd3);
        #1;
        chk("t1_valid", out_valid, 1);
        chk("t1_ready", in_ready, 4'b0001);
        chk("t1_grant", grant_idx, 0);
        chk("t1_source", out_source, 9'h015);
        chk("t1_addr", out_address, 30'h0000_1000);
        chk("t1_opcode", out_opcode, 3'd4);
        cyc();
        in_valid[0] = 1'b0;
        #1;
        chk("t1_locked", locked, 0);

        // 8-beat PutFull from req1 with req2 Get waiting
        set_req(1, 1'b1, 3'd0, 4'd6);
        set_req(2, 1'b1, 3'd4, 4'd3);
        for (int b = 0; b < 8; b++) begin
            #1;
            chk("t2_grant", grant_idx, 1);
            chk("t2_ready", in_ready, 4'b0010);
            chk("t2_locked", locked, (b != 0));
            if (b == 0) chk("t2_data", out_data, 64'hDA7A_0000_0000_0001);
            cyc();
        end
        in_valid[1] = 1'b0;
        #1;
        chk("t2_after_grant", grant_idx, 2);
        chk("t2_after_ready", in_ready, 4'b0100);
        chk("t2_after_locked", locked, 0);
        cyc();
        in_valid[2] = 1'b0;

        // All four single-beat Gets; rr_ptr is now 3
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'd4, 4'd3);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_grant", grant_idx, exp_rr[k]);
            chk("t3_ready", in_ready, 4'b0001 << exp_rr[k]);
            cyc();
        end
        in_valid = '0;

        // 4-beat burst on req1 with out_ready gaps; req3 raised mid-burst
        set_req(1, 1'b1, 3'd0, 4'd5);
        for (int k = 0; k < 7; k++) begin
            out_ready = rdy_pat[k];
            if (k == 2) set_req(3, 1'b1, 3'd4, 4'd3);
            #1;
            chk("t4_grant", grant_idx, 1);
            chk("t4_locked", locked, (k != 0));
            chk("t4_ready", in_ready, rdy_pat[k] ? 4'b0010 : 4'b0000);
            cyc();
        end
        in_valid[1] = 1'b0;
        out_ready   = 1'b1;
        #1;
        chk("t4_release_locked", locked, 0);
        chk("t4_next_grant", grant_idx, 3);
        cyc();
        in_valid[3] = 1'b0;

        // Move rr_ptr to 2, start an 8-beat burst on req2, gap, then reset mid-burst
        set_req(1, 1'b1, 3'd4, 4'd3);
        #1;
        chk("t5_pre_grant", grant_idx, 1);
        cyc();
        in_valid[1] = 1'b0;
        set_req(2, 1'b1, 3'd0, 4'd6);
        for (int b = 0; b < 3; b++) begin
            #1;
            chk("t5_grant", grant_idx, 2);
            cyc();
        end
        in_valid[2] = 1'b0;
        set_req(3, 1'b1, 3'd4, 4'd3);
        #1;
        chk("t5_gap_valid", out_valid, 0);
        chk("t5_gap_locked", locked, 1);
        chk("t5_gap_grant", grant_idx, 2);
        cyc();
        in_valid[2] = 1'b1;
        in_valid[3] = 1'b0;
        #1;
        chk("t5_resume_locked", locked, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_locked", locked, 0);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", in_ready, 0);
        cyc();
        cyc();
        reset_n   = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        set_req(2, 1'b1, 3'd4, 4'd3);
        #1;
        chk("t5_stall_grant", grant_idx, 2);
        chk("t5_stall_valid", out_valid, 1);
        chk("t5_stall_ready", in_ready, 0);
        cyc();
        set_req(0, 1'b1, 3'd4, 4'd3);
        #1;
        chk("t5_preempt_grant", grant_idx, 0);
        out_ready = 1'b1;
        #1;
        chk("t5_preempt_ready", in_ready, 4'b0001);
        cyc();
        in_valid[0] = 1'b0;
        #1;
        chk("t5_stalled_wins", grant_idx, 2);
        cyc();
        in_valid[2] = 1'b0;

        // Oversized PutFull clamps to 8 beats; sub-beat PutPartial is single-beat
        set_req(3, 1'b1, 3'd0, 4'd7);
        for (int b = 0; b < 8; b++) begin
            #1;
            chk("t6_grant", grant_idx, 3);
            chk("t6_locked", locked, (b != 0));
            if (b == 0) chk("t6_source", out_source, 9'h1CC);
            cyc();
        end
        in_valid[3] = 1'b0;
        #1;
        chk("t6_release", locked, 0);
        set_req(0, 1'b1, 3'd1, 4'd2);
        #1;
        chk("t6_pp_grant", grant_idx, 0);
        cyc();
        in_valid[0] = 1'b0;
        #1;
        chk("t6_pp_locked", locked, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
